// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-pc select encoding.
package pc_pkg;

    localparam int unsigned PC_SEL_W = 3;

    typedef enum logic [2:0] {
        PC_INC      = 3'd0,
        PC_ZERO     = 3'd1,
        PC_REL      = 3'd2,
        PC_ABS      = 3'd3,
        PC_CALL_REL = 3'd4,
        PC_CALL_ABS = 3'd5,
        PC_RET      = 3'd6
    } pc_sel_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest
// entry; a pop from an empty stack is ignored and reported as an underflow pulse.
module ras_stack #(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         clear_i,
    input  logic [ADDR_W-1:0]            data_i,
    output logic [ADDR_W-1:0]            data_o,
    output logic [$clog2(RAS_DEPTH):0]   count_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         overflow_o,
    output logic                         underflow_o
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_m1;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              full, empty;

    // ptr_q is the next write slot; the top of stack sits one below it.
    assign ptr_m1 = ptr_q - PTR_W'(1);
    assign full   = (cnt_q == CNT_W'(RAS_DEPTH));
    assign empty  = (cnt_q == '0);

    assign data_o      = mem_q[ptr_m1];
    assign count_o     = cnt_q;
    assign full_o      = full;
    assign empty_o     = empty;
    assign overflow_o  = push_i & ~clear_i & full;
    assign underflow_o = pop_i & ~clear_i & ~push_i & empty;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (clear_i) begin
            ptr_d = '0;
            cnt_d = '0;
        end else if (push_i) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (!full) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop_i && !empty) begin
            ptr_d = ptr_m1;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !clear_i) begin
            mem_q[ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-pc mux and optional return-address stack.
// Define PC_UNIT_RAS_EN to build the RAS; otherwise call/return degrade to jumps.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load_pc,
    input  logic [PC_SEL_W-1:0]        pc_sel,
    input  logic [DATA_W-1:0]          offset,
    input  logic [DATA_W-1:0]          target,
    output logic [ADDR_W-1:0]          pc,
    output logic [ADDR_W-1:0]          link_addr,
    output logic [$clog2(RAS_DEPTH):0] ras_count,
    output logic                       ras_empty,
    output logic                       ras_full,
    output logic                       ras_overflow,
    output logic                       ras_underflow
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_plus1, pc_rel, tgt;

    assign tgt       = target[ADDR_W-1:0];
    assign pc_plus1  = pc_q + ADDR_W'(1);
    assign pc_rel    = pc_q + offset[ADDR_W-1:0];
    assign pc        = pc_q;
    assign link_addr = pc_plus1;

    generate
        if (DATA_W > ADDR_W) begin : g_trunc
            logic unused_hi;
            assign unused_hi = ^{offset[DATA_W-1:ADDR_W], target[DATA_W-1:ADDR_W]};
        end
    endgenerate

`ifdef PC_UNIT_RAS_EN
    logic                       push, pop, clr;
    logic [ADDR_W-1:0]          ras_top;
    logic                       ovf_pulse, udf_pulse;
    logic                       ovf_q, ovf_d, udf_q, udf_d;

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (push),
        .pop_i       (pop),
        .clear_i     (clr),
        .data_i      (pc_plus1),
        .data_o      (ras_top),
        .count_o     (ras_count),
        .full_o      (ras_full),
        .empty_o     (ras_empty),
        .overflow_o  (ovf_pulse),
        .underflow_o (udf_pulse)
    );

    assign ovf_d         = ovf_q | ovf_pulse;
    assign udf_d         = udf_q | udf_pulse;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = udf_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end
`else
    assign ras_count     = '0;
    assign ras_empty     = 1'b1;
    assign ras_full      = 1'b0;
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
`ifdef PC_UNIT_RAS_EN
        push = 1'b0;
        pop  = 1'b0;
        clr  = 1'b0;
`endif
        if (load_pc) begin
            case (pc_sel_t'(pc_sel))
                PC_ZERO: begin
                    pc_d = RST_PC;
`ifdef PC_UNIT_RAS_EN
                    clr  = 1'b1;
`endif
                end
                PC_REL:  pc_d = pc_rel;
                PC_ABS:  pc_d = tgt;
                PC_CALL_REL: begin
                    pc_d = pc_rel;
`ifdef PC_UNIT_RAS_EN
                    push = 1'b1;
`endif
                end
                PC_CALL_ABS: begin
                    pc_d = tgt;
`ifdef PC_UNIT_RAS_EN
                    push = 1'b1;
`endif
                end
                PC_RET: begin
`ifdef PC_UNIT_RAS_EN
                    // Empty stack falls back to the register-held return address.
                    pop  = 1'b1;
                    pc_d = ras_empty ? tgt : ras_top;
`else
                    pc_d = tgt;
`endif
                end
                default: pc_d = pc_plus1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= RST_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit; expectations follow the PC_UNIT_RAS_EN build setting.
module tb_pc_unit;
    import pc_pkg::*;

`ifdef PC_UNIT_RAS_EN
    localparam bit RAS = 1'b1;
`else
    localparam bit RAS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_pc;
    logic [2:0]  pc_sel;
    logic [15:0] offset;
    logic [15:0] target;
    logic [8:0]  pc;
    logic [8:0]  link_addr;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, ras_overflow, ras_underflow;

    int tests = 0;
    int fails = 0;

    pc_unit #(
        .ADDR_W    (9),
        .DATA_W    (16),
        .RAS_DEPTH (4),
        .RESET_PC  (0)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_pc       (load_pc),
        .pc_sel        (pc_sel),
        .offset        (offset),
        .target        (target),
        .pc            (pc),
        .link_addr     (link_addr),
        .ras_count     (ras_count),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [2:0] sel, input logic [15:0] off, input logic [15:0] tgt);
        load_pc = 1'b1;
        pc_sel  = sel;
        offset  = off;
        target  = tgt;
        @(posedge clk);
        #1;
        load_pc = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        load_pc = 1'b0;
        pc_sel  = PC_INC;
        offset  = '0;
        target  = '0;
        #12;
        chk("rst_pc", pc, 0);
        chk("rst_link", link_addr, 1);
        chk("rst_count", ras_count, 0);
        chk("rst_empty", ras_empty, 1);
        chk("rst_full", ras_full, 0);
        chk("rst_ovf", ras_overflow, 0);
        chk("rst_udf", ras_underflow, 0);
        @(negedge clk);
        reset_n = 1'b1;

        step(PC_INC, 0, 0);  chk("inc1", pc, 1);
        step(PC_INC, 0, 0);  chk("inc2", pc, 2);
        step(PC_INC, 0, 0);  chk("inc3", pc, 3);
        chk("inc_link", link_addr, 4);
        step(3'd7, 0, 0);    chk("reserved_inc", pc, 4);

        step(PC_ABS, 0, 5);          chk("abs5", pc, 5);
        step(PC_REL, 16'hFFFE, 0);   chk("rel_neg", pc, 3);
        step(PC_ABS, 0, 510);        chk("abs510", pc, 510);
        step(PC_REL, 16'd5, 0);      chk("rel_wrap", pc, 3);
        step(PC_ABS, 0, 16'hFFFF);   chk("abs_trunc", pc, 511);
        chk("link_wrap", link_addr, 0);

        step(PC_ABS, 0, 10);
        step(PC_CALL_ABS, 0, 100);   chk("call_pc", pc, 100);
        chk("call_cnt", ras_count, RAS ? 1 : 0);
        step(PC_INC, 0, 0);          chk("call_inc", pc, 101);
        chk("call_inc_cnt", ras_count, RAS ? 1 : 0);
        step(PC_RET, 0, 200);        chk("ret_pc", pc, RAS ? 11 : 200);
        chk("ret_cnt", ras_count, 0);

        step(PC_ZERO, 0, 0);         chk("zero_pc", pc, 0);
        for (int i = 0; i < 4; i++) step(PC_CALL_REL, 16'd2, 0);
        chk("push4_pc", pc, 8);
        chk("push4_full", ras_full, RAS ? 1 : 0);
        chk("push4_ovf", ras_overflow, 0);
        step(PC_CALL_REL, 16'd2, 0);
        chk("push5_pc", pc, 10);
        chk("push5_cnt", ras_count, RAS ? 4 : 0);
        chk("push5_ovf", ras_overflow, RAS ? 1 : 0);

        load_pc = 1'b0;
        pc_sel  = PC_CALL_ABS;
        target  = 300;
        @(posedge clk); #1;
        chk("hold_pc", pc, 10);
        chk("hold_cnt", ras_count, RAS ? 4 : 0);

        step(PC_RET, 0, 77);         chk("pop1", pc, RAS ? 9 : 77);
        step(PC_RET, 0, 77);         chk("pop2", pc, RAS ? 7 : 77);
        step(PC_RET, 0, 77);         chk("pop3", pc, RAS ? 5 : 77);
        step(PC_RET, 0, 77);         chk("pop4", pc, RAS ? 3 : 77);
        chk("pop4_empty", ras_empty, 1);
        chk("pop4_udf", ras_underflow, 0);
        step(PC_RET, 0, 77);         chk("pop5_pc", pc, 77);
        chk("pop5_cnt", ras_count, 0);
        chk("pop5_udf", ras_underflow, RAS ? 1 : 0);

        step(PC_ZERO, 0, 0);         chk("zero2_pc", pc, 0);
        chk("sticky_ovf", ras_overflow, RAS ? 1 : 0);
        chk("sticky_udf", ras_underflow, RAS ? 1 : 0);

        step(PC_CALL_ABS, 0, 50);
        step(PC_CALL_ABS, 0, 60);    chk("push2_cnt", ras_count, RAS ? 2 : 0);
        step(PC_ZERO, 0, 0);         chk("zero_clr_cnt", ras_count, 0);
        chk("zero_clr_empty", ras_empty, 1);
        step(PC_CALL_ABS, 0, 50);
        step(PC_CALL_ABS, 0, 60);    chk("repush_pc", pc, 60);
        chk("repush_cnt", ras_count, RAS ? 2 : 0);

        load_pc = 1'b1;
        pc_sel  = PC_INC;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_pc", pc, 0);
        chk("arst_cnt", ras_count, 0);
        chk("arst_ovf", ras_overflow, 0);
        chk("arst_udf", ras_underflow, 0);
        @(posedge clk); #1;
        chk("arst_hold_pc", pc, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(PC_INC, 0, 0);          chk("post_rst_inc", pc, 1);
        step(PC_RET, 0, 42);         chk("ret_empty_pc", pc, 42);
        chk("ret_empty_flag", ras_empty, 1);
        chk("ret_empty_udf", ras_underflow, RAS ? 1 : 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
